// File: rtl/cpu_pkg.sv
// Shared definitions for the RISC CPU fetch/decode path.
//   - opcode_e      : 3-bit opcode encodings seen by the controller
//   - DEF_*         : default widths for the instruction register
//   - cnt_width()   : bit width of a modulo-n index, never less than 1
package cpu_pkg;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_e;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_OPC_W     = 3;
  localparam int DEF_NUM_BEATS = 2;

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ir_beat_ctr.sv
// Modulo-NUM_BEATS beat counter for the instruction register.
//   clk, rst  : clock, synchronous active-high reset
//   inc       : advance to the next beat (wraps after the last one)
//   clr       : return to beat 0; overrides inc
//   beat_idx  : index of the next beat expected
//   last_beat : beat_idx addresses the final beat of the word
module ir_beat_ctr #(
  parameter int NUM_BEATS = 2,
  parameter int CNT_W     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] beat_idx,
  output logic             last_beat
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_BEATS - 1);

  assign last_beat = (beat_idx == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_idx <= '0;
    end else if (clr) begin
      beat_idx <= '0;
    end else if (inc) begin
      beat_idx <= last_beat ? '0 : beat_idx + CNT_W'(1);
    end
  end

endmodule

// File: rtl/instr_reg_multibeat.sv
// Multi-beat instruction register. Assembles one INSTR_W-bit word from
// NUM_BEATS MSB-first bus beats, commits it atomically and slices it into
// opcode/address fields. The committed word is held while the next one is
// assembled in a separate shadow register.
//   clk, rst    : clock, synchronous active-high reset
//   data        : instruction beat from the memory bus
//   load        : capture data this cycle
//   clr         : abort partial assembly and invalidate the instruction
//   instr       : last committed instruction word
//   opcode      : top OPC_W bits of instr
//   addr        : low ADDR_W bits of instr
//   instr_valid : committed instruction valid
//   instr_done  : one-cycle pulse in the cycle after a commit
//   beat_idx    : index of the next beat expected
module instr_reg_multibeat
  import cpu_pkg::*;
#(
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int NUM_BEATS = DEF_NUM_BEATS,
  parameter  int OPC_W     = DEF_OPC_W,
  localparam int INSTR_W   = DATA_W * NUM_BEATS,
  localparam int ADDR_W    = INSTR_W - OPC_W,
  localparam int CNT_W     = cnt_width(NUM_BEATS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  data,
  input  logic               load,
  input  logic               clr,
  output logic [INSTR_W-1:0] instr,
  output logic [OPC_W-1:0]   opcode,
  output logic [ADDR_W-1:0]  addr,
  output logic               instr_valid,
  output logic               instr_done,
  output logic [CNT_W-1:0]   beat_idx
);

  logic [INSTR_W-1:0] shadow;
  logic [INSTR_W-1:0] commit_word;
  logic               accept;
  logic               last_beat;
  logic               commit;

  assign accept = load & ~clr;
  assign commit = accept & last_beat;

  ir_beat_ctr #(
    .NUM_BEATS (NUM_BEATS),
    .CNT_W     (CNT_W)
  ) u_ctr (
    .clk       (clk),
    .rst       (rst),
    .inc       (accept),
    .clr       (clr),
    .beat_idx  (beat_idx),
    .last_beat (last_beat)
  );

  // Upper beats come from the shadow, the final beat straight from the bus,
  // so the whole word lands in instr on one edge. Written as an overlay
  // rather than a concatenation so NUM_BEATS=1 needs no special case.
  always_comb begin
    commit_word               = shadow;
    commit_word[DATA_W-1:0]   = data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow      <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      instr_done  <= 1'b0;
    end else begin
      instr_done <= commit;
      if (clr) begin
        instr_valid <= 1'b0;
      end else if (accept) begin
        for (int unsigned k = 0; k < NUM_BEATS; k++) begin
          if (beat_idx == CNT_W'(k)) begin
            shadow[INSTR_W-1-k*DATA_W -: DATA_W] <= data;
          end
        end
        if (last_beat) begin
          instr       <= commit_word;
          instr_valid <= 1'b1;
        end
      end
    end
  end

  assign opcode = instr[INSTR_W-1 -: OPC_W];
  assign addr   = instr[ADDR_W-1:0];

endmodule

// File: tb/tb_instr_reg_multibeat.sv
// Bench for instr_reg_multibeat: a 2-beat default instance and a 3-beat
// (OPC_W=5) instance, each checked every cycle against a queue-based model,
// plus directed literal expectations.
module tb_instr_reg_multibeat;
  import cpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance: 8 x 2, opcode 3
  logic        rst, load, clr;
  logic [7:0]  data;
  logic [15:0] instr;
  logic [2:0]  opcode;
  logic [12:0] addr;
  logic        instr_valid, instr_done;
  logic        beat_idx;

  // variant instance: 8 x 3, opcode 5
  logic        rst3, load3, clr3;
  logic [7:0]  data3;
  logic [23:0] instr3;
  logic [4:0]  opcode3;
  logic [18:0] addr3;
  logic        instr_valid3, instr_done3;
  logic [1:0]  beat_idx3;

  instr_reg_multibeat dut (
    .clk(clk), .rst(rst), .data(data), .load(load), .clr(clr),
    .instr(instr), .opcode(opcode), .addr(addr),
    .instr_valid(instr_valid), .instr_done(instr_done), .beat_idx(beat_idx)
  );

  instr_reg_multibeat #(.DATA_W(8), .NUM_BEATS(3), .OPC_W(5)) dut3 (
    .clk(clk), .rst(rst3), .data(data3), .load(load3), .clr(clr3),
    .instr(instr3), .opcode(opcode3), .addr(addr3),
    .instr_valid(instr_valid3), .instr_done(instr_done3), .beat_idx(beat_idx3)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      passed++;
  endtask

  // Model: beats accepted so far for the word in progress, plus the last
  // committed word and its flags.
  logic [7:0]  q2[$];
  logic [15:0] m_instr  = '0;
  logic        m_valid  = 1'b0;
  logic        m_done   = 1'b0;
  logic [7:0]  q3[$];
  logic [23:0] m_instr3 = '0;
  logic        m_valid3 = 1'b0;
  logic        m_done3  = 1'b0;
  int          edges    = 0;

  always @(posedge clk) begin
    edges++;
    m_done = 1'b0;
    if (rst) begin
      q2.delete(); m_instr = '0; m_valid = 1'b0;
    end else if (clr) begin
      q2.delete(); m_valid = 1'b0;
    end else if (load) begin
      q2.push_back(data);
      if (q2.size() == 2) begin
        m_instr = '0;
        foreach (q2[i]) m_instr = (m_instr << 8) | 16'(q2[i]);
        q2.delete(); m_valid = 1'b1; m_done = 1'b1;
      end
    end

    m_done3 = 1'b0;
    if (rst3) begin
      q3.delete(); m_instr3 = '0; m_valid3 = 1'b0;
    end else if (clr3) begin
      q3.delete(); m_valid3 = 1'b0;
    end else if (load3) begin
      q3.push_back(data3);
      if (q3.size() == 3) begin
        m_instr3 = '0;
        foreach (q3[i]) m_instr3 = (m_instr3 << 8) | 24'(q3[i]);
        q3.delete(); m_valid3 = 1'b1; m_done3 = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (edges > 0) begin
      chk("m2.instr",  instr,       m_instr);
      chk("m2.opcode", opcode,      m_instr[15:13]);
      chk("m2.addr",   addr,        m_instr[12:0]);
      chk("m2.valid",  instr_valid, m_valid);
      chk("m2.done",   instr_done,  m_done);
      chk("m2.idx",    beat_idx,    q2.size());
      chk("m3.instr",  instr3,       m_instr3);
      chk("m3.opcode", opcode3,      m_instr3[23:19]);
      chk("m3.addr",   addr3,        m_instr3[18:0]);
      chk("m3.valid",  instr_valid3, m_valid3);
      chk("m3.done",   instr_done3,  m_done3);
      chk("m3.idx",    beat_idx3,    q3.size());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int dones;

  initial begin
    rst = 1'b1; load = 1'b1; clr = 1'b0; data = 8'hFF;
    rst3 = 1'b1; load3 = 1'b1; clr3 = 1'b0; data3 = 8'hFF;
    step(); step();
    chk("rst.instr", instr, 16'h0000);
    chk("rst.valid", instr_valid, 1'b0);
    chk("rst.done",  instr_done, 1'b0);
    chk("rst.idx",   beat_idx, 1'b0);
    chk("rst3.instr", instr3, 24'h0);

    // two beats, then idle with junk on the bus
    rst = 1'b0; load = 1'b1; data = 8'hA5;
    rst3 = 1'b0; load3 = 1'b0;
    step();
    chk("b0.idx", beat_idx, 1'b1);
    chk("b0.instr_held", instr, 16'h0000);
    data = 8'h3C;
    step();
    load = 1'b0; data = 8'hCC;
    chk("a53c.instr",  instr, 16'hA53C);
    chk("a53c.opcode", opcode, 3'b101);
    chk("a53c.addr",   addr, 13'h053C);
    chk("a53c.valid",  instr_valid, 1'b1);
    chk("a53c.done",   instr_done, 1'b1);
    step();
    chk("a53c.done_drop", instr_done, 1'b0);
    step(); step();
    chk("a53c.hold", instr, 16'hA53C);

    // partial beat aborted by clr
    load = 1'b1; data = 8'h12;
    step();
    load = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr.idx",   beat_idx, 1'b0);
    chk("clr.valid", instr_valid, 1'b0);
    chk("clr.instr", instr, 16'hA53C);
    load = 1'b1; data = 8'hE0;
    step();
    data = 8'h07;
    step();
    load = 1'b0;
    chk("e007.instr",  instr, 16'hE007);
    chk("e007.opcode", opcode, JMP);
    chk("e007.valid",  instr_valid, 1'b1);

    // clr wins over a load on the final beat
    load = 1'b1; data = 8'hAA;
    step();
    clr = 1'b1; data = 8'h99;
    step();
    clr = 1'b0; load = 1'b0;
    chk("clrwin.done",  instr_done, 1'b0);
    chk("clrwin.idx",   beat_idx, 1'b0);
    chk("clrwin.instr", instr, 16'hE007);

    // continuous load
    dones = 0;
    load = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      data = 8'(i);
      step();
      if (instr_done) dones++;
      if (i == 2) chk("stream.0102", instr, 16'h0102);
      if (i == 3) chk("stream.hold", instr, 16'h0102);
      if (i == 4) chk("stream.0304", instr, 16'h0304);
    end
    load = 1'b0;
    chk("stream.0506", instr, 16'h0506);
    chk("stream.dones", dones, 3);

    // unknown bus data while idle
    data = 'x;
    step(); step();
    chk("xidle.instr", instr, 16'h0506);
    data = 8'h00;

    // 3-beat variant
    load3 = 1'b1; data3 = 8'h81;
    step();
    data3 = 8'h22;
    step();
    chk("v3.idx2", beat_idx3, 2'd2);
    data3 = 8'h33;
    step();
    load3 = 1'b0;
    chk("v3.instr",  instr3, 24'h812233);
    chk("v3.opcode", opcode3, 5'b10000);
    chk("v3.addr",   addr3, 19'h12233);
    chk("v3.done",   instr_done3, 1'b1);
    load3 = 1'b1; data3 = 8'h44;
    step();
    data3 = 8'h55;
    step();
    rst3 = 1'b1; data3 = 8'h66;
    step();
    rst3 = 1'b0; load3 = 1'b0;
    chk("v3rst.instr", instr3, 24'h0);
    chk("v3rst.valid", instr_valid3, 1'b0);
    chk("v3rst.done",  instr_done3, 1'b0);
    chk("v3rst.idx",   beat_idx3, 2'd0);
    step(); step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_reg_multibeat.md
Name: instr_reg_multibeat

Overview:
Parametrised instruction register for the RISC CPU fetch path. It succeeds the fixed 8-bit load register. It assembles one instruction word from NUM_BEATS consecutive DATA_W-wide bus beats, commits the word atomically, and decodes it into opcode and address fields for the controller. It supports abort/flush and holds the committed instruction stable while the next one is being fetched.

Parameters:
DATA_W, 8, width of one bus beat (data input)
NUM_BEATS, 2, beats per instruction (>=1)
OPC_W, 3, opcode field width (must be < DATA_W*NUM_BEATS)
Derived: INSTR_W = DATA_W*NUM_BEATS; ADDR_W = INSTR_W-OPC_W; CNT_W = max(1, clog2(NUM_BEATS))

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
data  in  DATA_W  instruction beat from memory bus
load  in  1  capture data this cycle
clr  in  1  flush: abort partial assembly, invalidate instruction
instr  out  INSTR_W  last committed instruction word
opcode  out  OPC_W  instr[INSTR_W-1 -: OPC_W]
addr  out  ADDR_W  instr[ADDR_W-1:0]
instr_valid  out  1  committed instruction valid
instr_done  out  1  one-cycle pulse, cycle after commit
beat_idx  out  CNT_W  index of next beat expected (0..NUM_BEATS-1)

Behaviour:
- Reset (rst=1 at posedge): instr=0, shadow=0, beat_idx=0, instr_valid=0, instr_done=0. Reset overrides clr and load.
- Beat order: MSB-first. Beat k lands in shadow bits [INSTR_W-1-k*DATA_W -: DATA_W].
- load=1, clr=0, beat_idx<NUM_BEATS-1: write beat to shadow slot; beat_idx+1. instr, instr_valid unchanged.
- load=1, clr=0, beat_idx==NUM_BEATS-1 (commit): instr <= {shadow upper beats, data} in one edge; beat_idx wraps to 0; instr_valid<=1; instr_done<=1 for exactly that following cycle.
- load=0, clr=0: all state holds. instr_done<=0.
- clr=1: beat_idx<=0, instr_valid<=0, instr_done<=0. instr and shadow retain values. Any load in the same cycle is dropped (clr wins).
- Latency: instr/opcode/addr/instr_valid/instr_done visible the cycle after the final beat's edge. opcode and addr are combinational slices of registered instr, with no extra delay.
- instr stays constant during partial assembly of the next instruction. instr_valid stays 1 until clr or rst.
- NUM_BEATS=1: every accepted load commits. beat_idx constant 0 (1 bit wide).
- Back-to-back loads: no bubble required. A commit and the next beat 0 may occur on consecutive edges.
- load held high continuously: one instruction commits every NUM_BEATS cycles.
- X on data with load=0 must not propagate to any output.

Decomposition:
- Package cpu_pkg: opcode constants HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7 (3-bit); default DATA_W and OPC_W constants.
- Sub-module ir_beat_ctr: modulo-NUM_BEATS counter with inc, clr, rst. Outputs beat_idx and last_beat. The top level holds the shadow/instr datapath and the done/valid flags.

Test Plan:
1. rst=1 for 2 cycles with load=1, data=8'hFF -> instr=16'h0000, instr_valid=0, instr_done=0, beat_idx=0.
2. Defaults: load 8'hA5 then 8'h3C on consecutive cycles -> next cycle instr=16'hA53C, opcode=3'b101, addr=13'h053C, instr_valid=1, instr_done high exactly 1 cycle. Then load=0 with data=8'hCC for 3 cycles -> instr holds 16'hA53C.
3. After commit of 16'hA53C: load 8'h12, then clr=1 -> beat_idx=0, instr_valid=0, instr still 16'hA53C. Then load 8'hE0, 8'h07 -> instr=16'hE007, opcode=3'b111.
4. At beat_idx=1, assert clr=1 with load=1 and data=8'h99 -> no commit, instr_done stays 0, beat_idx=0.
5. load held high for 6 cycles with data 01,02,03,04,05,06 -> commits 16'h0102, 16'h0304, 16'h0506 on every 2nd edge. instr_done pulses 3 times. instr stays 16'h0102 while 8'h03 is pending.
6. Parameter variant DATA_W=8, NUM_BEATS=3, OPC_W=5: load 8'h81, 8'h22, 8'h33 -> instr=24'h812233, opcode=5'b10000, addr=19'h12233. Also rst asserted after 2 beats -> all outputs zero next cycle.
